// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- instruction decode stage.
//
// Takes the fetch stage's {pc, instruction} stream into an IF/ID register,
// reads a 32x32 register file (written by write-back), resolves
// BEZ/BNE/JMP combinationally and redirects fetch, and drives a registered
// ID/EX bundle to execute.
//
// Optional feature macro: ID_WB_BYPASS_EN
//   defined   : a write-back in the same cycle as the read is forwarded to
//               rs/rt (operands and branch compares), never for r0.
//   undefined : reads return the pre-write register contents.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_pc, if_instruction   fetch stream
//   wb_we, wb_dest, wb_data register-file write port
//   branch_taken, branch_address  fetch redirect (combinational from IF/ID)
//   ex_*                registered ID/EX bundle
// ---------------------------------------------------------------------------
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        wb_we,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_val1,
    output logic [31:0] ex_val2,
    output logic [31:0] ex_imm,
    output logic        ex_use_imm,
    output logic [3:0]  ex_alu_cmd,
    output logic [4:0]  ex_dest,
    output logic        ex_wb_en,
    output logic        ex_mem_read,
    output logic        ex_mem_write
);

    localparam logic [5:0] OP_ADD  = 6'd1,  OP_SUB  = 6'd3,  OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6,  OP_NOR  = 6'd7,  OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9,  OP_SLL  = 6'd10, OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12, OP_ADDI = 6'd32, OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36, OP_ST   = 6'd37, OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41, OP_JMP  = 6'd42;

    // IF/ID register
    logic [31:0] r_pc_id;
    logic [31:0] r_instr_id;
    logic        r_valid_id;

    // register file; r0 is never written so it always reads 0
    logic [31:0] r_regs [32];

    logic [5:0]  w_op;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm;
    logic [31:0] w_rs_val, w_rt_val;

    assign w_op  = r_instr_id[31:26];
    assign w_rs  = r_instr_id[25:21];
    assign w_rt  = r_instr_id[20:16];
    assign w_rd  = r_instr_id[15:11];
    assign w_imm = {{16{r_instr_id[15]}}, r_instr_id[15:0]};

    always_comb begin
        w_rs_val = r_regs[w_rs];
        w_rt_val = r_regs[w_rt];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && (wb_dest != 5'd0) && (wb_dest == w_rs)) w_rs_val = wb_data;
        if (wb_we && (wb_dest != 5'd0) && (wb_dest == w_rt)) w_rt_val = wb_data;
`endif
    end

    // ---------------- decode ----------------
    logic       w_live;      // instruction produces a non-bubble ID/EX entry
    logic       w_rtype;
    logic       w_use_imm, w_wb_en, w_mem_read, w_mem_write;
    logic [3:0] w_alu_cmd;
    logic [4:0] w_dest;

    always_comb begin
        w_live      = 1'b0;
        w_rtype     = 1'b0;
        w_use_imm   = 1'b0;
        w_wb_en     = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_alu_cmd   = 4'b0000;
        w_dest      = 5'd0;
        case (w_op)
            OP_ADD:  begin w_rtype = 1'b1; w_alu_cmd = 4'b0000; end
            OP_SUB:  begin w_rtype = 1'b1; w_alu_cmd = 4'b0010; end
            OP_AND:  begin w_rtype = 1'b1; w_alu_cmd = 4'b0100; end
            OP_OR:   begin w_rtype = 1'b1; w_alu_cmd = 4'b0101; end
            OP_NOR:  begin w_rtype = 1'b1; w_alu_cmd = 4'b0110; end
            OP_XOR:  begin w_rtype = 1'b1; w_alu_cmd = 4'b0111; end
            OP_SLA:  begin w_rtype = 1'b1; w_alu_cmd = 4'b1000; end
            OP_SLL:  begin w_rtype = 1'b1; w_alu_cmd = 4'b1000; end
            OP_SRA:  begin w_rtype = 1'b1; w_alu_cmd = 4'b1001; end
            OP_SRL:  begin w_rtype = 1'b1; w_alu_cmd = 4'b1010; end
            OP_ADDI: begin w_live = 1'b1; w_use_imm = 1'b1; w_wb_en = 1'b1; w_dest = w_rt; end
            OP_SUBI: begin w_live = 1'b1; w_use_imm = 1'b1; w_wb_en = 1'b1; w_dest = w_rt;
                           w_alu_cmd = 4'b0010; end
            OP_LD:   begin w_live = 1'b1; w_use_imm = 1'b1; w_wb_en = 1'b1; w_dest = w_rt;
                           w_mem_read = 1'b1; end
            OP_ST:   begin w_live = 1'b1; w_use_imm = 1'b1; w_mem_write = 1'b1; end
            default: ;  // NOP, branches, undefined opcodes: bubble
        endcase
        if (w_rtype) begin
            w_live  = 1'b1;
            w_wb_en = 1'b1;
            w_dest  = w_rd;
        end
        if (!r_valid_id) w_live = 1'b0;
    end

    // ---------------- branch resolve ----------------
    assign branch_taken = r_valid_id &
                          (((w_op == OP_BEZ) && (w_rs_val == 32'd0)) ||
                           ((w_op == OP_BNE) && (w_rs_val != w_rt_val)) ||
                            (w_op == OP_JMP));
    assign branch_address = r_pc_id + 32'd4 + {w_imm[29:0], 2'b00};

    // ---------------- IF/ID ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_id    <= 32'd0;
            r_instr_id <= 32'd0;
            r_valid_id <= 1'b0;
        end else begin
            r_pc_id    <= if_pc;
            r_instr_id <= if_instruction;
            r_valid_id <= ~branch_taken;   // flush the wrong-path fetch
        end
    end

    // ---------------- register file ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (wb_we && (wb_dest != 5'd0)) begin
            r_regs[wb_dest] <= wb_data;
        end
    end

    // ---------------- ID/EX ----------------
    // Bubbles (reset, flushed slot, NOP, branch, undefined) clear the whole bundle.
    always_ff @(posedge clk) begin
        if (rst || !w_live) begin
            ex_pc        <= 32'd0;
            ex_val1      <= 32'd0;
            ex_val2      <= 32'd0;
            ex_imm       <= 32'd0;
            ex_use_imm   <= 1'b0;
            ex_alu_cmd   <= 4'b0000;
            ex_dest      <= 5'd0;
            ex_wb_en     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            ex_pc        <= r_pc_id;
            ex_val1      <= w_rs_val;
            ex_val2      <= w_rt_val;
            ex_imm       <= w_imm;
            ex_use_imm   <= w_use_imm;
            ex_alu_cmd   <= w_alu_cmd;
            ex_dest      <= w_dest;
            ex_wb_en     <= w_wb_en;
            ex_mem_read  <= w_mem_read;
            ex_mem_write <= w_mem_write;
        end
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage: the consumer of the fetch stage's `{PC, Instruction}` stream and the producer of its `branch_taken` / `branch_address` redirect.
- Latches each fetched instruction into an IF/ID register and reads a 32×32 register file that the write-back stage writes.
- Resolves BEZ/BNE/JMP and redirects fetch, flushing the one wrong-path instruction.
- Drives a registered ID/EX bundle to the execute stage.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_pc` in 32: PC of the instruction currently presented by fetch.
- `if_instruction` in 32: fetched instruction.
- `wb_we` in 1: register-file write enable from write-back.
- `wb_dest` in 5: write-back destination register.
- `wb_data` in 32: write-back data.
- `branch_taken` out 1: redirect fetch (combinational from IF/ID contents).
- `branch_address` out 32: redirect target.
- `ex_pc` out 32: PC of the instruction in ID/EX.
- `ex_val1` out 32: source-1 operand.
- `ex_val2` out 32: source-2 operand; store data for ST.
- `ex_imm` out 32: sign-extended `instr[15:0]`.
- `ex_use_imm` out 1: ALU operand 2 comes from `ex_imm`.
- `ex_alu_cmd` out 4: ALU operation.
- `ex_dest` out 5: destination register.
- `ex_wb_en` out 1: write-back enable.
- `ex_mem_read` out 1: memory read (LD).
- `ex_mem_write` out 1: memory write (ST).

## Operation
Fields: op=`[31:26]`, rs=`[25:21]`, rt=`[20:16]`, rd=`[15:11]`, imm=`[15:0]`.

Opcode map (all R-type use dest=rd, srcs rs/rt, wb_en=1):

| Opcode | Instruction | Class / operands | `ex_alu_cmd` |
|---|---|---|---|
| 0 | NOP | no effect | 0000 |
| 1 | ADD | R-type | 0000 |
| 3 | SUB | R-type | 0010 |
| 5 | AND | R-type | 0100 |
| 6 | OR | R-type | 0101 |
| 7 | NOR | R-type | 0110 |
| 8 | XOR | R-type | 0111 |
| 9 | SLA | R-type | 1000 |
| 10 | SLL | R-type | 1000 |
| 11 | SRA | R-type | 1001 |
| 12 | SRL | R-type | 1010 |
| 32 | ADDI | dest=rt, src rs, use_imm=1, wb_en=1 | 0000 |
| 33 | SUBI | dest=rt, src rs, use_imm=1, wb_en=1 | 0010 |
| 36 | LD | dest=rt, base rs, use_imm=1, mem_read=1, wb_en=1 | 0000 |
| 37 | ST | base rs, store data rt into `ex_val2`, use_imm=1, mem_write=1, wb_en=0 | 0000 |
| 40 | BEZ | taken iff R[rs]==0 | — |
| 41 | BNE | taken iff R[rs]!=R[rt] | — |
| 42 | JMP | always taken | — |

- Undefined opcodes decode as NOP.
- Branch target: `branch_address = pc_id + 4 + (sext(imm) << 2)`, with 32-bit wrap-around.
- Branch gating: `branch_taken` is asserted only when the IF/ID valid bit is 1.
- Branches enter ID/EX as a bubble: wb_en, mem_read and mem_write all 0.
- Bubble encoding: every `ex_*` control bit is 0, and `ex_alu_cmd` is 0000.
- Register file writes:
  - A write happens on the posedge when `wb_we`=1.
  - r0 is hardwired to 0; writes to r0 are ignored.
  - Reads are asynchronous.
- Flush: when `branch_taken`=1, the next IF/ID load is a bubble (valid=0), discarding the instruction fetched in that cycle.

## Timing
- IF/ID register loads `{if_pc, if_instruction, valid=1}` every posedge, except during a flush.
- Decode, register read and branch resolve are combinational from IF/ID.
- ID/EX loads on the next posedge. Latency is 1 cycle from IF/ID to the `ex_*` outputs.
- Redirect: `branch_taken` is asserted in the cycle the branch sits in IF/ID, and fetch loads the target at the next edge. Branch penalty is 1 cycle.
- Reset (`rst`=1 at a posedge):
  - IF/ID valid=0.
  - All `ex_*` outputs are 0.
  - All 32 registers are 0.
  - `branch_taken`=0 and `branch_address`=4 (IF/ID `pc_id`=0, imm=0).
  - `rst` overrides flush and write-back in the same cycle.
- Reset mid-branch: a branch in IF/ID when `rst` asserts is discarded, and no redirect occurs after reset.
- A write-back to register X in the same cycle that ID reads X is governed by the configuration macro below.
- A write-back to r0 together with a read of r0 returns 0 regardless of the macro.

## Configuration
- Macro: `ID_WB_BYPASS_EN`.
- Defined: when `wb_we` is set, `wb_dest`≠0 and `wb_dest` matches rs/rt, the read returns `wb_data` in the same cycle. This applies to both operands and to branch compares.
- Undefined: reads return the pre-write value, and the program must insert NOPs to cover the hazard.

## Test plan
- Reset: hold `rst` for 2 cycles, then present NOPs.
  - Expect `branch_taken`=0 and all `ex_*`=0.
  - Reading r1..r31 via ADD yields `ex_val1`=0.
- R-type decode:
  - Stimulus: write r1=1546 via write-back, then present `ADD r2,r0,r1` (op1, rs0, rt1, rd2) at PC 16.
  - Expect next cycle: `ex_val1`=0, `ex_val2`=1546, `ex_alu_cmd`=0000, `ex_dest`=2, `ex_wb_en`=1, `ex_pc`=16.
- Bypass: `wb_we`=1, `wb_dest`=5, `wb_data`=7 in the same cycle that `XOR r7,r5,r1` is in IF/ID.
  - With the macro: `ex_val1`=7.
  - Without the macro: `ex_val1`=old r5 (0).
  - Repeat with `wb_dest`=0: `ex_val1` reads 0 in both builds.
- BNE taken: r1=3, r3=2, `BNE r1,r3,-15` at PC 296.
  - Expect `branch_taken`=1 and `branch_address`=240.
  - The following cycle IF/ID is a bubble, and the cycle after that all `ex_*` control bits are 0.
- Not-taken and jump:
  - `BEZ r5,1` with r5=1546: expect `branch_taken`=0, and the next instruction enters ID normally.
  - `JMP -1` at PC 376: expect `branch_address`=376, `branch_taken`=1.
- Memory decode: r1=1024.
  - `LD r6,r8,-4`: expect `ex_imm`=0xFFFFFFFC, `ex_mem_read`=1, `ex_dest`=6.
  - `ST r7,r1,20`: expect `ex_val2`=R[7], `ex_mem_write`=1, `ex_wb_en`=0.
  - Undefined opcode 63: expect a bubble.
